// File: rtl/lsu_pkg.sv
// Shared types and encodings for the memory-stage load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // The reserved size encoding behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] tc, input logic [1:0] a);
        case (tc)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/grant/response bus seen from the load/store controller.
interface mem_access_ctrl_if #(parameter int DATA_WIDTH = 32);
    logic                    dmem_req;
    logic                    dmem_we;
    logic [DATA_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH/8-1:0] dmem_be;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic                    dmem_gnt;
    logic                    dmem_rvalid;
    logic [DATA_WIDTH-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Store byte-lane steering and load-data extraction/extension (purely combinational).
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]              type_i,
    input  logic [1:0]              addr_i,
    input  logic                    sign_ext_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    output logic [DATA_WIDTH/8-1:0] be_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH-1:0]   ldata_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (type_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (type_i)
            SZ_BYTE: ldata_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: ldata_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            default: ldata_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: request/grant/response FSM, pipeline stall, load result register.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and raise M_misalign.
module mem_access_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  M_mem_write,
    input  logic [1:0]            M_result_src,
    input  logic [1:0]            M_type_control,
    input  logic                  M_sign_ext_flag,
    input  logic [DATA_WIDTH-1:0] M_alu_result,
    input  logic [DATA_WIDTH-1:0] M_write_data,
    output logic                  M_stall,
    output logic [DATA_WIDTH-1:0] M_load_data,
    output logic                  M_misalign,
    mem_access_ctrl_if.master     dmem
);
    lsu_state_e            state_q;
    logic [DATA_WIDTH-1:0] load_data_q;
    logic                  misalign_q;

    logic                    is_store, is_load, access, trap, issue;
    logic [DATA_WIDTH/8-1:0] be_w;
    logic [DATA_WIDTH-1:0]   wdata_w, ldata_w;

    // A store wins when both write and load-select are set.
    assign is_store = M_mem_write;
    assign is_load  = ~M_mem_write & (M_result_src == RES_MEM);
    assign access   = is_store | is_load;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = access & is_misaligned(M_type_control, M_alu_result[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .type_i     (M_type_control),
        .addr_i     (M_alu_result[1:0]),
        .sign_ext_i (M_sign_ext_flag),
        .wdata_i    (M_write_data),
        .rdata_i    (dmem.dmem_rdata),
        .be_o       (be_w),
        .wdata_o    (wdata_w),
        .ldata_o    (ldata_w)
    );

    // Request is gated by reset so it drops the instant reset asserts.
    assign issue = rst & access & ~trap &
                   ((state_q == ST_IDLE) | (state_q == ST_WAIT_GNT));

    assign dmem.dmem_req   = issue;
    assign dmem.dmem_we    = issue & is_store;
    assign dmem.dmem_be    = issue ? be_w : '0;
    assign dmem.dmem_addr  = {M_alu_result[DATA_WIDTH-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata_w;

    assign M_stall     = access & (state_q != ST_DONE);
    assign M_load_data = load_data_q;
    assign M_misalign  = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trap) begin
                        state_q    <= ST_DONE;
                        misalign_q <= 1'b1;
                        if (is_load) load_data_q <= '0;
                    end else if (access) begin
                        if (dmem.dmem_gnt) state_q <= is_store ? ST_DONE : ST_WAIT_RSP;
                        else               state_q <= ST_WAIT_GNT;
                    end
                end
                ST_WAIT_GNT: begin
                    if (dmem.dmem_gnt) state_q <= is_store ? ST_DONE : ST_WAIT_RSP;
                end
                ST_WAIT_RSP: begin
                    if (dmem.dmem_rvalid) begin
                        load_data_q <= ldata_w;
                        state_q     <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
